// File: rtl/periph_timer_ctrl.sv
// Memory-mapped timer/LED/switch/7-seg peripheral at 0x4000_0000.
// TL counts prescaled ticks, reloads from TH on overflow and raises irq when IE is set.
module periph_timer_ctrl #(
  parameter int PRESCALE = 1,
  parameter int SW_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         addr,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic [SW_WIDTH-1:0] switch_in,
  output logic [7:0]          led,
  output logic [11:0]         digi,
  output logic                irq
);

  localparam logic [25:0] BASE_PAGE = 26'h100_0000;
  localparam int          PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam logic [3:0] OFF_TH   = 4'h0;
  localparam logic [3:0] OFF_TL   = 4'h1;
  localparam logic [3:0] OFF_TCON = 4'h2;
  localparam logic [3:0] OFF_LED  = 4'h3;
  localparam logic [3:0] OFF_SW   = 4'h4;
  localparam logic [3:0] OFF_DIGI = 4'h5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } count_state_e;

  count_state_e        state;
  count_state_e        state_next;

  logic [31:0]         th;
  logic [31:0]         tl;
  logic                tcon_en;
  logic                tcon_ie;
  logic                tcon_st;
  logic [PW-1:0]       ps_count;
  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;

  logic                page_hit;
  logic [3:0]          offset;
  logic                wr_th;
  logic                wr_tl;
  logic                wr_tcon;
  logic                wr_led;
  logic                wr_digi;
  logic                en_next;
  logic                run_active;
  logic                tick;
  logic                overflow;
  logic                unused_addr_bits;

  assign page_hit         = (addr[31:6] == BASE_PAGE);
  assign offset           = addr[5:2];
  assign unused_addr_bits = ^addr[1:0];

  assign wr_th   = wr_en && page_hit && (offset == OFF_TH);
  assign wr_tl   = wr_en && page_hit && (offset == OFF_TL);
  assign wr_tcon = wr_en && page_hit && (offset == OFF_TCON);
  assign wr_led  = wr_en && page_hit && (offset == OFF_LED);
  assign wr_digi = wr_en && page_hit && (offset == OFF_DIGI);

  assign en_next = wr_tcon ? wdata[0] : tcon_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // State tracks the EN bit as it will be after this edge, so RUN coincides with EN=1
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en_next)  state_next = RUN;
      RUN:     if (!en_next) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    run_active = (state == RUN);
    tick       = run_active && (ps_count == PS_LAST);
    overflow   = tick && (tl == 32'hFFFF_FFFF);
  end

  // Writing TCON with EN=0 restarts the prescale phase; otherwise it holds while stopped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_count <= '0;
    end else if (wr_tcon && !wdata[0]) begin
      ps_count <= '0;
    end else if (run_active) begin
      ps_count <= (ps_count == PS_LAST) ? '0 : ps_count + PW'(1);
    end
  end

  // A CPU write to TL beats a tick; an overflow reloads from TH as it was before this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th <= '0;
      tl <= '0;
    end else begin
      if (wr_th) begin
        th <= wdata;
      end
      if (wr_tl) begin
        tl <= wdata;
      end else if (tick) begin
        tl <= overflow ? th : tl + 32'd1;
      end
    end
  end

  // An overflow setting ST wins over a simultaneous software clear so no interrupt is lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcon_en <= 1'b0;
      tcon_ie <= 1'b0;
      tcon_st <= 1'b0;
    end else begin
      if (wr_tcon) begin
        tcon_en <= wdata[0];
        tcon_ie <= wdata[1];
      end
      if (overflow && tcon_ie) begin
        tcon_st <= 1'b1;
      end else if (wr_tcon) begin
        tcon_st <= wdata[2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led  <= '0;
      digi <= '0;
    end else begin
      if (wr_led) begin
        led <= wdata[7:0];
      end
      if (wr_digi) begin
        digi <= wdata[11:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
    end
  end

  assign irq = tcon_st && tcon_ie;

  always_comb begin
    rdata = '0;
    if (rd_en && page_hit) begin
      case (offset)
        OFF_TH:   rdata = th;
        OFF_TL:   rdata = tl;
        OFF_TCON: rdata = {29'd0, tcon_st, tcon_ie, tcon_en};
        OFF_LED:  rdata = {24'd0, led};
        OFF_SW:   rdata = 32'(sw_sync);
        OFF_DIGI: rdata = {20'd0, digi};
        default:  rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_timer_ctrl.sv
// Randomized bench for periph_timer_ctrl: drives a PRESCALE=1 and a PRESCALE=4 instance
// with the same bus traffic and checks both against a register-level reference model.
module tb_periph_timer_ctrl;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [7:0]  switch_in;

  logic [31:0] rdata_p1;
  logic [7:0]  led_p1;
  logic [11:0] digi_p1;
  logic        irq_p1;
  logic [31:0] rdata_p4;
  logic [7:0]  led_p4;
  logic [11:0] digi_p4;
  logic        irq_p4;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_p1;
  logic [31:0] obs_p4;
  logic        obs_irq_p1;
  logic [7:0]  sw_cur;

  // Reference model state, index 0 = PRESCALE 1, index 1 = PRESCALE 4
  logic [31:0] m_th   [2];
  logic [31:0] m_tl   [2];
  logic        m_en   [2];
  logic        m_ie   [2];
  logic        m_st   [2];
  logic [7:0]  m_led  [2];
  logic [11:0] m_digi [2];
  int          m_phase[2];
  logic [7:0]  m_sw_meta;
  logic [7:0]  m_sw_sync;

  periph_timer_ctrl #(.PRESCALE(1), .SW_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata_p1), .switch_in(switch_in),
    .led(led_p1), .digi(digi_p1), .irq(irq_p1)
  );

  periph_timer_ctrl #(.PRESCALE(4), .SW_WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata_p4), .switch_in(switch_in),
    .led(led_p4), .digi(digi_p4), .irq(irq_p4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int prescale_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] model_read(input int i, input logic [31:0] a);
    logic [25:0] page;
    logic [3:0]  off;
    page = a[31:6];
    off  = a[5:2];
    if (page != 26'h100_0000) return 32'd0;
    case (off)
      4'h0:    return m_th[i];
      4'h1:    return m_tl[i];
      4'h2:    return {29'd0, m_st[i], m_ie[i], m_en[i]};
      4'h3:    return {24'd0, m_led[i]};
      4'h4:    return {24'd0, m_sw_sync};
      4'h5:    return {20'd0, m_digi[i]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_th[i] = 32'd0; m_tl[i] = 32'd0;
      m_en[i] = 1'b0;  m_ie[i] = 1'b0; m_st[i] = 1'b0;
      m_led[i] = 8'd0; m_digi[i] = 12'd0; m_phase[i] = 0;
    end
    m_sw_meta = 8'd0;
    m_sw_sync = 8'd0;
  endtask

  // One rising edge of the reference model, using the bus inputs currently driven
  task automatic model_clock();
    logic        hit;
    logic [3:0]  off;
    logic        tick;
    logic        wrap;
    logic [31:0] old_th;
    hit = (addr[31:6] == 26'h100_0000) && wr_en;
    off = addr[5:2];
    for (int i = 0; i < 2; i++) begin
      tick   = m_en[i] && (m_phase[i] == prescale_of(i) - 1);
      wrap   = tick && (m_tl[i] == 32'hFFFF_FFFF);
      old_th = m_th[i];
      if (hit && off == 4'h1)      m_tl[i] = wdata;
      else if (wrap)               m_tl[i] = old_th;
      else if (tick)               m_tl[i] = m_tl[i] + 32'd1;
      if (hit && off == 4'h0)      m_th[i] = wdata;
      if (hit && off == 4'h2 && !wdata[0]) m_phase[i] = 0;
      else if (m_en[i])            m_phase[i] = (m_phase[i] + 1) % prescale_of(i);
      if (wrap && m_ie[i])         m_st[i] = 1'b1;
      else if (hit && off == 4'h2) m_st[i] = wdata[2];
      if (hit && off == 4'h2) begin
        m_en[i] = wdata[0];
        m_ie[i] = wdata[1];
      end
      if (hit && off == 4'h3)      m_led[i]  = wdata[7:0];
      if (hit && off == 4'h5)      m_digi[i] = wdata[11:0];
    end
    m_sw_sync = m_sw_meta;
    m_sw_meta = switch_in;
  endtask

  // Drives one bus cycle starting just after a rising edge, checks at the falling edge
  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] a,
                               input logic [31:0] wd, input logic [7:0] sw);
    wr_en = we; rd_en = re; addr = a; wdata = wd; switch_in = sw;
    @(negedge clk);
    obs_p1     = rdata_p1;
    obs_p4     = rdata_p4;
    obs_irq_p1 = irq_p1;
    checkOutput("rdata_p1", rdata_p1, re ? model_read(0, a) : 32'd0);
    checkOutput("rdata_p4", rdata_p4, re ? model_read(1, a) : 32'd0);
    checkOutput("led_p1", 32'(led_p1), 32'(m_led[0]));
    checkOutput("led_p4", 32'(led_p4), 32'(m_led[1]));
    checkOutput("digi_p1", 32'(digi_p1), 32'(m_digi[0]));
    checkOutput("digi_p4", 32'(digi_p4), 32'(m_digi[1]));
    checkOutput("irq_p1", 32'(irq_p1), 32'(m_st[0] & m_ie[0]));
    checkOutput("irq_p4", 32'(irq_p4), 32'(m_st[1] & m_ie[1]));
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, a, d, sw_cur);
  endtask

  task automatic bus_read(input logic [31:0] a);
    applyStimulus(1'b0, 1'b1, a, 32'd0, sw_cur);
  endtask

  // Asserts reset between edges and checks that state clears without waiting for a clock
  task automatic reset_pulse();
    #2;
    wr_en = 1'b0; rd_en = 1'b1; addr = A_TL;
    reset = 1'b0;
    #1;
    checkOutput("rst_tl_p1", rdata_p1, 32'd0);
    checkOutput("rst_tl_p4", rdata_p4, 32'd0);
    checkOutput("rst_led", 32'(led_p1), 32'd0);
    checkOutput("rst_digi", 32'(digi_p1), 32'd0);
    checkOutput("rst_irq", 32'({irq_p1, irq_p4}), 32'd0);
    addr = A_TCON;
    #1;
    checkOutput("rst_tcon", rdata_p1, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic        re;
    int          off;

    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = 32'd0; wdata = 32'd0;
    sw_cur = 8'd0; switch_in = 8'd0;
    model_reset();
    #1;
    reset_pulse();

    // Overflow reload from TH and interrupt raise/clear
    bus_write(A_TH, 32'hFFFF_FFF0);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'd3);
    bus_read(A_TL);  checkOutput("t2_tl_start", obs_p1, 32'hFFFF_FFFE);
    bus_read(A_TL);  checkOutput("t2_tl_1clk", obs_p1, 32'hFFFF_FFFF);
    bus_read(A_TL);  checkOutput("t2_tl_reload", obs_p1, 32'hFFFF_FFF0);
    checkOutput("t2_irq_set", 32'(obs_irq_p1), 32'd1);
    bus_read(A_TL);  checkOutput("t2_irq_hold", 32'(obs_irq_p1), 32'd1);
    bus_write(A_TCON, 32'd3);
    bus_read(A_TL);  checkOutput("t2_tl_counting", obs_p1, 32'hFFFF_FFF3);
    checkOutput("t2_irq_cleared", 32'(obs_irq_p1), 32'd0);

    // Overflow with IE=0 reloads without setting ST
    bus_write(A_TCON, 32'd1);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_read(A_TL);  checkOutput("t3_tl_max", obs_p1, 32'hFFFF_FFFF);
    bus_read(A_TL);  checkOutput("t3_tl_reload", obs_p1, 32'hFFFF_FFF0);
    bus_read(A_TCON); checkOutput("t3_tcon", obs_p1, 32'd1);
    checkOutput("t3_irq", 32'(obs_irq_p1), 32'd0);

    // Same-edge conflicts: ST set beats clear, TL write beats tick
    bus_write(A_TCON, 32'd3);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'd3);
    bus_read(A_TCON); checkOutput("t4_tcon_st_wins", obs_p1, 32'd7);
    checkOutput("t4_irq", 32'(obs_irq_p1), 32'd1);
    bus_write(A_TL, 32'd5);
    bus_read(A_TL);  checkOutput("t4_tl_write_wins", obs_p1, 32'd5);

    // Bus registers, unmapped offsets and the switch synchronizer
    bus_write(A_LED, 32'h0000_00A5);
    bus_write(A_DIGI, 32'h0000_03F7);
    bus_read(32'h4000_0018);
    checkOutput("t6_unmapped", obs_p1, 32'd0);
    checkOutput("t6_led", 32'(led_p1), 32'h0000_00A5);
    checkOutput("t6_digi", 32'(digi_p1), 32'h0000_03F7);
    bus_read(32'h4000_0040); checkOutput("t6_other_page", obs_p1, 32'd0);
    bus_read(A_LED | 32'd3); checkOutput("t6_byte_lanes", obs_p1, 32'h0000_00A5);
    sw_cur = 8'h5A;
    bus_read(A_SW);  checkOutput("t6_sw_0clk", obs_p1, 32'd0);
    bus_read(A_SW);  checkOutput("t6_sw_1clk", obs_p1, 32'd0);
    bus_read(A_SW);  checkOutput("t6_sw_2clk", obs_p1, 32'h0000_005A);

    // Reset while counting with LED/DIGI populated
    reset_pulse();

    // Prescaled counting, pause and resume on the PRESCALE=4 instance
    bus_write(A_TCON, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) begin
        bus_write(A_TCON, 32'd0);
      end else if (k == 7) begin
        bus_write(A_TCON, 32'd1);
      end else begin
        bus_read(A_TL);
        checkOutput($sformatf("t5_tl_k%0d", k), obs_p4,
                    (k < 5) ? 32'd0 : ((k < 12) ? 32'd1 : 32'd2));
      end
    end

    // Random traffic, biased toward overflows and enabled counting
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
      end else begin
        off = $urandom_range(0, 7);
        a   = (($urandom_range(0, 19) == 0) ? 32'h4000_0100 : A_TH)
              + 32'(off * 4) + 32'($urandom_range(0, 3));
        we  = ($urandom_range(0, 2) == 0);
        re  = ($urandom_range(0, 1) == 1);
        wd  = $urandom;
        if (off == 1 && $urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        if (off == 0 && $urandom_range(0, 1) == 1) wd = 32'($urandom_range(0, 255));
        if (off == 2) wd[0] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 15) == 0) sw_cur = 8'($urandom);
        applyStimulus(we, re, a, wd, sw_cur);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
